wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wbq_pkg.sv | 16 +
 rtl/wbq_lookup.sv | 41 ++++
 rtl/wb_queue.sv | 118 +++++++++++
 tb/tb_wb_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared definitions for the writeback queue.
//   XLEN        : default register data width
//   XZR         : register number of the zero register; writes to it are dropped
//   wbq_entry_t : one pending register write {wa, wd}
package wbq_pkg;

  localparam int XLEN = 64;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the pending-write queue for one forwarding port.
// Ports:
//   head  : slot index of the oldest entry
//   valid : per-slot valid flags
//   wa/wd : per-slot destination register and data
//   ra    : lookup register number
//   hit   : some valid entry targets ra (never for the zero register)
//   data  : data of the youngest matching entry, 0 when no hit
module wbq_lookup
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [PW-1:0]                 head,
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][4:0]         wa,
  input  logic [DEPTH-1:0][XLEN-1:0]    wd,
  input  logic [4:0]                    ra,
  output logic                          hit,
  output logic [XLEN-1:0]               data
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (wa[idx] == ra) && (ra != XZR)) begin
        hit  = 1'b1;
        data = wd[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers register-file writes while the write port is
// busy, drains them in order, and forwards pending values to two readers.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : writeback request handshake
//   in_wa, in_wd          : request destination register and data
//   rf_hold               : register file write port unavailable this cycle
//   rf_we3/rf_wa3/rf_wd3  : register file write port
//   fwd_raN               : forwarding lookup register numbers
//   fwd_hitN, fwd_dataN   : forwarding result per lookup
//   count                 : number of pending entries
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_wa,
  input  logic [XLEN-1:0]              in_wd,
  input  logic                         rf_hold,
  output logic                         rf_we3,
  output logic [4:0]                   rf_wa3,
  output logic [XLEN-1:0]              rf_wd3,
  input  logic [4:0]                   fwd_ra1,
  input  logic [4:0]                   fwd_ra2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [XLEN-1:0]              fwd_data1,
  output logic [XLEN-1:0]              fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  import wbq_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]                count_q;
  logic [PW-1:0]                head_q;
  logic [PW-1:0]                tail_q;
  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][4:0]        wa_q;
  logic [DEPTH-1:0][XLEN-1:0]   wd_q;

  logic nonempty;
  logic accept;
  logic push;
  logic drain;

  assign nonempty = (count_q != '0);
  // Registered state only: a draining full queue still refuses this cycle.
  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // Zero-register writes are accepted and silently dropped.
  assign push     = accept && (in_wa != XZR);
  assign drain    = nonempty && !rf_hold;

  assign rf_we3 = drain;
  assign rf_wa3 = nonempty ? wa_q[head_q] : 5'd0;
  assign rf_wd3 = nonempty ? wd_q[head_q] : '0;
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      // Full is the only case where tail == head with a drain, and then
      // push is blocked, so set/clear never hit the same slot.
      if (push) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (push && !drain) begin
        count_q <= count_q + CW'(1);
      end else if (drain && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Payload storage is qualified by valid_q/count_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[tail_q] <= in_wa;
      wd_q[tail_q] <= in_wd;
    end
  end

  wbq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_lookup1 (
    .head  (head_q),
    .valid (valid_q),
    .wa    (wa_q),
    .wd    (wd_q),
    .ra    (fwd_ra1),
    .hit   (fwd_hit1),
    .data  (fwd_data1)
  );

  wbq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_lookup2 (
    .head  (head_q),
    .valid (valid_q),
    .wa    (wa_q),
    .wd    (wd_q),
    .ra    (fwd_ra2),
    .hit   (fwd_hit2),
    .data  (fwd_data2)
  );

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_wa;
  logic [XLEN-1:0]   in_wd;
  logic              rf_hold;
  logic              rf_we3;
  logic [4:0]        rf_wa3;
  logic [XLEN-1:0]   rf_wd3;
  logic [4:0]        fwd_ra1;
  logic [4:0]        fwd_ra2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [XLEN-1:0]   fwd_data1;
  logic [XLEN-1:0]   fwd_data2;
  logic [2:0]        count;

  int checks;
  int failures;

  wbq_pkg::wbq_entry_t mq[$];

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wa     (in_wa),
    .in_wd     (in_wd),
    .rf_hold   (rf_hold),
    .rf_we3    (rf_we3),
    .rf_wa3    (rf_wa3),
    .rf_wd3    (rf_wd3),
    .fwd_ra1   (fwd_ra1),
    .fwd_ra2   (fwd_ra2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_wa    = 5'd0;
    in_wd    = '0;
    rf_hold  = 1'b0;
    fwd_ra1  = 5'd0;
    fwd_ra2  = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    fwd_ra1 = 5'd3;
    fwd_ra2 = 5'd31;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", rf_we3); end
    checks++; if (rf_wa3 !== 5'd0) begin failures++; $display("FAIL reset_wa got=%0h exp=0", rf_wa3); end
    checks++; if (rf_wd3 !== 64'd0) begin failures++; $display("FAIL reset_wd got=%0h exp=0", rf_wd3); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0h%0h exp=00", fwd_hit1, fwd_hit2); end
    checks++; if (fwd_data1 !== 64'd0 || fwd_data2 !== 64'd0) begin failures++; $display("FAIL reset_data got=%0h/%0h exp=0/0", fwd_data1, fwd_data2); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_wa = 5'd5; in_wd = 64'hAA;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0h exp=1", in_ready); end
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL single_we_empty got=%0h exp=0", rf_we3); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_we3 !== 1'b1) begin failures++; $display("FAIL single_we got=%0h exp=1", rf_we3); end
    checks++; if (rf_wa3 !== 5'd5) begin failures++; $display("FAIL single_wa got=%0h exp=5", rf_wa3); end
    checks++; if (rf_wd3 !== 64'hAA) begin failures++; $display("FAIL single_wd got=%0h exp=aa", rf_wd3); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
    step();
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL single_we_after got=%0h exp=0", rf_we3); end
  endtask

  task automatic test_forward();
    do_reset();
    rf_hold = 1'b1;
    in_valid = 1'b1; in_wa = 5'd3; in_wd = 64'h11;
    step();
    in_wd = 64'h22;
    step();
    in_valid = 1'b1; in_wa = 5'd4; in_wd = 64'h33;
    fwd_ra1 = 5'd3; fwd_ra2 = 5'd4;
    #1;
    checks++; if (fwd_hit1 !== 1'b1) begin failures++; $display("FAIL fwd_hit1 got=%0h exp=1", fwd_hit1); end
    checks++; if (fwd_data1 !== 64'h22) begin failures++; $display("FAIL fwd_youngest got=%0h exp=22", fwd_data1); end
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL fwd_count got=%0d exp=2", count); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin failures++; $display("FAIL fwd_no_bypass got=%0h/%0h exp=0/0", fwd_hit2, fwd_data2); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 64'h33) begin failures++; $display("FAIL fwd_hit2 got=%0h/%0h exp=1/33", fwd_hit2, fwd_data2); end
    rf_hold = 1'b0;
    #1;
    checks++; if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd3 || rf_wd3 !== 64'h11) begin failures++; $display("FAIL fwd_drain_head got=%0h/%0h/%0h exp=1/3/11", rf_we3, rf_wa3, rf_wd3); end
    step();
    step();
    #1;
    checks++; if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd4) begin failures++; $display("FAIL fwd_last_head got=%0h/%0h exp=1/4", rf_we3, rf_wa3); end
    checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 64'h33) begin failures++; $display("FAIL fwd_draining_hit got=%0h/%0h exp=1/33", fwd_hit2, fwd_data2); end
    checks++; if (fwd_hit1 !== 1'b0) begin failures++; $display("FAIL fwd_drained_miss got=%0h exp=0", fwd_hit1); end
    step();
    #1;
    checks++; if (count !== 3'd0 || fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin failures++; $display("FAIL fwd_empty got=%0d/%0h/%0h exp=0/0/0", count, fwd_hit2, fwd_data2); end
  endtask

  task automatic test_full();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_wa = 5'(i); in_wd = 64'h100 + 64'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_fill_ready%0d got=%0h exp=1", i, in_ready); end
      step();
    end
    in_wa = 5'd5; in_wd = 64'h105;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL full_held%0d got=%0h/%0d exp=0/4", i, in_ready, count); end
      step();
    end
    rf_hold = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_drain_ready got=%0h exp=0", in_ready); end
    checks++; if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd1) begin failures++; $display("FAIL full_first_drain got=%0h/%0h exp=1/1", rf_we3, rf_wa3); end
    step();
    #1;
    checks++; if (in_ready !== 1'b1 || count !== 3'd3 || rf_wa3 !== 5'd2) begin failures++; $display("FAIL full_resume got=%0h/%0d/%0h exp=1/3/2", in_ready, count, rf_wa3); end
    step();
    in_valid = 1'b0;
    for (int j = 3; j <= 5; j++) begin
      #1;
      checks++; if (rf_we3 !== 1'b1 || rf_wa3 !== 5'(j) || rf_wd3 !== 64'h100 + 64'(j)) begin failures++; $display("FAIL full_order%0d got=%0h/%0h/%0h exp=1/%0h/%0h", j, rf_we3, rf_wa3, rf_wd3, j, 64'h100 + 64'(j)); end
      step();
    end
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", count); end
  endtask

  task automatic test_xzr();
    do_reset();
    in_valid = 1'b1; in_wa = 5'd31; in_wd = 64'hFF;
    fwd_ra2 = 5'd31;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL xzr_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || rf_we3 !== 1'b0) begin failures++; $display("FAIL xzr_dropped got=%0d/%0h exp=0/0", count, rf_we3); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin failures++; $display("FAIL xzr_fwd got=%0h/%0h exp=0/0", fwd_hit2, fwd_data2); end
    step();
    #1;
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL xzr_no_write got=%0h exp=0", rf_we3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      in_valid = 1'b1; in_wa = 5'(i); in_wd = 64'h700 + 64'(i);
      step();
    end
    in_valid = 1'b0;
    rf_hold = 1'b0;
    fwd_ra1 = 5'd8;
    #1;
    checks++; if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd7 || count !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0h/%0h/%0d exp=1/7/3", rf_we3, rf_wa3, count); end
    step();
    #1 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || rf_we3 !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mid_async got=%0h/%0h/%0d exp=1/0/0", in_ready, rf_we3, count); end
    checks++; if (rf_wa3 !== 5'd0 || rf_wd3 !== 64'd0) begin failures++; $display("FAIL mid_port got=%0h/%0h exp=0/0", rf_wa3, rf_wd3); end
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0) begin failures++; $display("FAIL mid_fwd got=%0h/%0h exp=0/0", fwd_hit1, fwd_data1); end
    step();
    checks++; if (rf_we3 !== 1'b0) begin failures++; $display("FAIL mid_in_reset got=%0h exp=0", rf_we3); end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rf_we3 !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mid_after%0d got=%0h/%0d exp=0/0", i, rf_we3, count); end
    end
  endtask

  task automatic test_random();
    wbq_pkg::wbq_entry_t e;
    int n;
    logic acc;
    logic exp_we;
    logic [4:0] exp_wa;
    logic [XLEN-1:0] exp_wd;
    logic eh1, eh2;
    logic [XLEN-1:0] ed1, ed2;
    int bad;
    do_reset();
    mq.delete();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      rf_hold  = ($urandom_range(0, 99) < 45);
      in_valid = ($urandom_range(0, 99) < 70);
      n = $urandom_range(0, 9); in_wa   = (n >= 8) ? 5'd31 : 5'(n);
      n = $urandom_range(0, 9); fwd_ra1 = (n >= 8) ? 5'd31 : 5'(n);
      n = $urandom_range(0, 9); fwd_ra2 = (n >= 8) ? 5'd31 : 5'(n);
      in_wd = {$urandom, $urandom};
      #1;
      n = mq.size();
      exp_we = (n != 0) && !rf_hold;
      exp_wa = (n != 0) ? mq[0].wa : 5'd0;
      exp_wd = (n != 0) ? mq[0].wd : '0;
      eh1 = 1'b0; ed1 = '0; eh2 = 1'b0; ed2 = '0;
      foreach (mq[i]) begin
        if (mq[i].wa == fwd_ra1 && fwd_ra1 != 5'd31) begin eh1 = 1'b1; ed1 = mq[i].wd; end
        if (mq[i].wa == fwd_ra2 && fwd_ra2 != 5'd31) begin eh2 = 1'b1; ed2 = mq[i].wd; end
      end
      checks++; if (in_ready !== (n < DEPTH) || count !== 3'(n)) begin failures++; bad++; $display("FAIL rnd_occ c=%0d got=%0h/%0d exp=%0h/%0d", c, in_ready, count, n < DEPTH, n); end
      checks++; if (rf_we3 !== exp_we || rf_wa3 !== exp_wa || rf_wd3 !== exp_wd) begin failures++; bad++; $display("FAIL rnd_write c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, rf_we3, rf_wa3, rf_wd3, exp_we, exp_wa, exp_wd); end
      checks++; if (fwd_hit1 !== eh1 || fwd_data1 !== ed1) begin failures++; bad++; $display("FAIL rnd_fwd1 c=%0d got=%0h/%0h exp=%0h/%0h", c, fwd_hit1, fwd_data1, eh1, ed1); end
      checks++; if (fwd_hit2 !== eh2 || fwd_data2 !== ed2) begin failures++; bad++; $display("FAIL rnd_fwd2 c=%0d got=%0h/%0h exp=%0h/%0h", c, fwd_hit2, fwd_data2, eh2, ed2); end
      acc = in_valid && (n < DEPTH);
      step();
      if (exp_we) void'(mq.pop_front());
      if (acc && in_wa != 5'd31) begin
        e.wa = in_wa; e.wd = in_wd;
        mq.push_back(e);
      end
      if (bad > 20) break;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_forward();
    test_full();
    test_xzr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
